pipe_hazard_response: RTL and testbench

Registered consumer of the hazard detection unit's stall/flush controls. It owns the PC register, the IF/ID pipeline register and the control half of the ID/EX register. It applies PCWrite/IFIDWrite/IF_Flush/Hazard_Ctrl to them, inserting bubbles and NOPs cycle-accurately. It also tracks stall runs, counts bubbles and flushes, and flags illegal control combinations and runaway stalls for debug.

---
 rtl/pipe_hazard_response_if.sv | 39 +++
 rtl/pipe_hazard_response.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_response.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_response_if.sv
// Bundle of hazard-control inputs and pipeline-register outputs shared by the
// hazard response block and whoever drives it.
interface pipe_hazard_response_if #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);
    logic              PCWrite;
    logic              IFIDWrite;
    logic              IF_Flush;
    logic              Hazard_Ctrl;
    logic [31:0]       Next_PC;
    logic [31:0]       IF_Instr;
    logic [31:0]       IF_PC_4;
    logic [CTRL_W-1:0] ID_Ctrl;
    logic [31:0]       PC;
    logic [31:0]       ID_Instr;
    logic [31:0]       ID_PC_4;
    logic [CTRL_W-1:0] EX_Ctrl;
    logic [3:0]        Stall_Run;
    logic [CNT_W-1:0]  Bubble_CNT;
    logic [CNT_W-1:0]  Flush_CNT;
    logic              Stall_Err;
    logic              Ctrl_Err;
    logic [1:0]        State;

    modport slave (
        input  PCWrite, IFIDWrite, IF_Flush, Hazard_Ctrl,
               Next_PC, IF_Instr, IF_PC_4, ID_Ctrl,
        output PC, ID_Instr, ID_PC_4, EX_Ctrl, Stall_Run,
               Bubble_CNT, Flush_CNT, Stall_Err, Ctrl_Err, State
    );

    modport master (
        output PCWrite, IFIDWrite, IF_Flush, Hazard_Ctrl,
               Next_PC, IF_Instr, IF_PC_4, ID_Ctrl,
        input  PC, ID_Instr, ID_PC_4, EX_Ctrl, Stall_Run,
               Bubble_CNT, Flush_CNT, Stall_Err, Ctrl_Err, State
    );
endinterface

// File: rtl/pipe_hazard_response.sv
// Applies hazard-unit stall/flush controls to the PC, IF/ID and ID/EX control
// registers, and keeps debug statistics on bubbles, flushes and stall runs.
module pipe_hazard_response #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
    parameter int          CTRL_W      = 16,
    parameter int          STALL_LIMIT = 3,
    parameter int          CNT_W       = 16
) (
    input logic                    CLK,
    input logic                    RESET,
    pipe_hazard_response_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_ERR   = 2'b10
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STALL_LIMIT);

    logic [31:0]       r_pc;
    logic [31:0]       r_id_instr_p1;
    logic [31:0]       r_id_pc4_p1;
    logic [CTRL_W-1:0] r_ex_ctrl_p2;
    logic [3:0]        r_stall_run;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              r_stall_err;
    logic              r_ctrl_err;
    state_t            r_state;
    logic              w_ctrl_bad;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [3:0] sat_inc_run(input logic [3:0] v);
        return (&v) ? v : v + 4'd1;
    endfunction

    // PC and IF/ID only move together legally; a bubble must coincide with a frozen front end.
    assign w_ctrl_bad = (bus.PCWrite != bus.IFIDWrite) || (bus.Hazard_Ctrl == bus.PCWrite);

    // PC register: load the selected next PC unless the front end is frozen.
    always_ff @(posedge CLK) begin
        if (RESET)
            r_pc <= PC_RESET;
        else if (bus.PCWrite)
            r_pc <= bus.Next_PC;
    end

    // IF/ID register: a stall holds and masks any flush; a flush injects a NOP.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_id_instr_p1 <= NOP_INSTR;
            r_id_pc4_p1   <= '0;
            r_flush_cnt   <= '0;
        end else if (bus.IFIDWrite) begin
            if (bus.IF_Flush) begin
                r_id_instr_p1 <= NOP_INSTR;
                r_id_pc4_p1   <= '0;
                r_flush_cnt   <= sat_inc_cnt(r_flush_cnt);
            end else begin
                r_id_instr_p1 <= bus.IF_Instr;
                r_id_pc4_p1   <= bus.IF_PC_4;
            end
        end
    end

    // ID/EX control: zero the bundle to create a bubble and count it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ex_ctrl_p2 <= '0;
            r_bubble_cnt <= '0;
        end else if (bus.Hazard_Ctrl) begin
            r_ex_ctrl_p2 <= '0;
            r_bubble_cnt <= sat_inc_cnt(r_bubble_cnt);
        end else begin
            r_ex_ctrl_p2 <= bus.ID_Ctrl;
        end
    end

    // Stall tracking FSM with run length, runaway detection and control sanity flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_RUN;
            r_stall_run <= '0;
            r_stall_err <= 1'b0;
            r_ctrl_err  <= 1'b0;
        end else begin
            r_stall_run <= bus.Hazard_Ctrl ? sat_inc_run(r_stall_run) : 4'd0;
            if (w_ctrl_bad)
                r_ctrl_err <= 1'b1;
            case (r_state)
                ST_RUN: begin
                    if (bus.Hazard_Ctrl)
                        r_state <= ST_STALL;
                end
                ST_STALL: begin
                    if (!bus.Hazard_Ctrl) begin
                        r_state <= ST_RUN;
                    end else if (r_stall_run == LIMIT) begin
                        r_state     <= ST_ERR;
                        r_stall_err <= 1'b1;
                    end
                end
                ST_ERR:  r_state <= ST_ERR;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.PC         = r_pc;
    assign bus.ID_Instr   = r_id_instr_p1;
    assign bus.ID_PC_4    = r_id_pc4_p1;
    assign bus.EX_Ctrl    = r_ex_ctrl_p2;
    assign bus.Stall_Run  = r_stall_run;
    assign bus.Bubble_CNT = r_bubble_cnt;
    assign bus.Flush_CNT  = r_flush_cnt;
    assign bus.Stall_Err  = r_stall_err;
    assign bus.Ctrl_Err   = r_ctrl_err;
    assign bus.State      = r_state;

endmodule

// File: tb/tb_pipe_hazard_response.sv
// Directed bench for pipe_hazard_response: reset, stalls, flushes, runaway
// stall detection, control mismatch and bubble counter saturation.
module tb_pipe_hazard_response;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pipe_hazard_response_if #(.CTRL_W(16), .CNT_W(16)) bus ();

    pipe_hazard_response dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pcw, input logic ifw, input logic fl, input logic hz,
                         input logic [31:0] npc, input logic [31:0] ins, input logic [31:0] pc4,
                         input logic [15:0] ctl);
        bus.PCWrite     = pcw;
        bus.IFIDWrite   = ifw;
        bus.IF_Flush    = fl;
        bus.Hazard_Ctrl = hz;
        bus.Next_PC     = npc;
        bus.IF_Instr    = ins;
        bus.IF_PC_4     = pc4;
        bus.ID_Ctrl     = ctl;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset for two cycles while the front end asks to advance.
        rst = 1'b1;
        drive(1, 1, 0, 0, 32'h40, 32'h1111_1111, 32'h4, 16'h00F3);
        step();
        step();
        chk("rst_pc",     bus.PC, 32'h0);
        chk("rst_instr",  bus.ID_Instr, 32'h0);
        chk("rst_pc4",    bus.ID_PC_4, 32'h0);
        chk("rst_ex",     32'(bus.EX_Ctrl), 32'h0);
        chk("rst_run",    32'(bus.Stall_Run), 32'h0);
        chk("rst_bub",    32'(bus.Bubble_CNT), 32'h0);
        chk("rst_fl",     32'(bus.Flush_CNT), 32'h0);
        chk("rst_serr",   32'(bus.Stall_Err), 32'h0);
        chk("rst_cerr",   32'(bus.Ctrl_Err), 32'h0);
        chk("rst_state",  32'(bus.State), 32'h0);

        // First free cycle.
        rst = 1'b0;
        step();
        chk("free_pc",    bus.PC, 32'h40);
        chk("free_instr", bus.ID_Instr, 32'h1111_1111);
        chk("free_pc4",   bus.ID_PC_4, 32'h4);
        chk("free_ex",    32'(bus.EX_Ctrl), 32'h00F3);

        // Move PC to 0x10.
        drive(1, 1, 0, 0, 32'h10, 32'h0000_0022, 32'h44, 16'h1234);
        step();
        chk("pc10",       bus.PC, 32'h10);
        chk("pc10_instr", bus.ID_Instr, 32'h22);

        // Single lw-use stall.
        drive(0, 0, 0, 1, 32'h14, 32'h8C22_0004, 32'h14, 16'hBEEF);
        step();
        chk("st_pc",      bus.PC, 32'h10);
        chk("st_instr",   bus.ID_Instr, 32'h22);
        chk("st_pc4",     bus.ID_PC_4, 32'h44);
        chk("st_ex",      32'(bus.EX_Ctrl), 32'h0);
        chk("st_bub",     32'(bus.Bubble_CNT), 32'h1);
        chk("st_run",     32'(bus.Stall_Run), 32'h1);
        chk("st_state",   32'(bus.State), 32'h1);

        // Release: IF/ID loads.
        drive(1, 1, 0, 0, 32'h14, 32'h8C22_0004, 32'h14, 16'hBEEF);
        step();
        chk("rel_pc",     bus.PC, 32'h14);
        chk("rel_instr",  bus.ID_Instr, 32'h8C22_0004);
        chk("rel_ex",     32'(bus.EX_Ctrl), 32'hBEEF);
        chk("rel_run",    32'(bus.Stall_Run), 32'h0);
        chk("rel_state",  32'(bus.State), 32'h0);

        // Branch flush without stall.
        drive(1, 1, 1, 0, 32'h80, 32'h3333_3333, 32'h18, 16'h0101);
        step();
        chk("fl_pc",      bus.PC, 32'h80);
        chk("fl_instr",   bus.ID_Instr, 32'h0);
        chk("fl_pc4",     bus.ID_PC_4, 32'h0);
        chk("fl_cnt",     32'(bus.Flush_CNT), 32'h1);
        chk("fl_cerr",    32'(bus.Ctrl_Err), 32'h0);

        // Normal fetch to put real content in IF/ID.
        drive(1, 1, 0, 0, 32'h84, 32'h0000_0055, 32'h84, 16'h0202);
        step();
        chk("n_instr",    bus.ID_Instr, 32'h55);

        // Stall and flush together: stall wins.
        drive(0, 0, 1, 1, 32'h100, 32'h0000_0044, 32'h88, 16'h0303);
        step();
        chk("sf_pc",      bus.PC, 32'h84);
        chk("sf_instr",   bus.ID_Instr, 32'h55);
        chk("sf_pc4",     bus.ID_PC_4, 32'h84);
        chk("sf_fl",      32'(bus.Flush_CNT), 32'h1);
        chk("sf_bub",     32'(bus.Bubble_CNT), 32'h2);
        chk("sf_ex",      32'(bus.EX_Ctrl), 32'h0);

        // Idle then load-to-branch double stall.
        drive(1, 1, 0, 0, 32'h88, 32'h0000_0077, 32'h8C, 16'h0404);
        step();
        drive(0, 0, 0, 1, 32'h90, 32'h0000_0099, 32'h90, 16'h0505);
        step();
        chk("lb_run1",    32'(bus.Stall_Run), 32'h1);
        step();
        chk("lb_run2",    32'(bus.Stall_Run), 32'h2);
        drive(1, 1, 0, 0, 32'h88, 32'h0000_0077, 32'h8C, 16'h0404);
        step();
        chk("lb_run0",    32'(bus.Stall_Run), 32'h0);
        chk("lb_serr",    32'(bus.Stall_Err), 32'h0);
        chk("lb_state",   32'(bus.State), 32'h0);
        chk("lb_bub",     32'(bus.Bubble_CNT), 32'h4);

        // Runaway stall: four consecutive stall cycles.
        drive(0, 0, 0, 1, 32'h90, 32'h0000_0099, 32'h90, 16'h0505);
        step();
        step();
        step();
        chk("ra3_state",  32'(bus.State), 32'h1);
        chk("ra3_serr",   32'(bus.Stall_Err), 32'h0);
        step();
        chk("ra4_state",  32'(bus.State), 32'h2);
        chk("ra4_serr",   32'(bus.Stall_Err), 32'h1);
        chk("ra4_run",    32'(bus.Stall_Run), 32'h4);
        drive(1, 1, 0, 0, 32'h88, 32'h0000_0077, 32'h8C, 16'h0404);
        step();
        chk("ra_hold_st", 32'(bus.State), 32'h2);
        chk("ra_hold_se", 32'(bus.Stall_Err), 32'h1);
        chk("ra_run0",    32'(bus.Stall_Run), 32'h0);
        chk("ra_cerr",    32'(bus.Ctrl_Err), 32'h0);
        chk("ra_instr",   bus.ID_Instr, 32'h77);

        // Control mismatch: PC moves, IF/ID holds.
        drive(1, 0, 0, 0, 32'h200, 32'h0000_0066, 32'h204, 16'h0606);
        step();
        chk("cm_pc",      bus.PC, 32'h200);
        chk("cm_instr",   bus.ID_Instr, 32'h77);
        chk("cm_cerr",    32'(bus.Ctrl_Err), 32'h1);
        drive(1, 1, 0, 0, 32'h204, 32'h0000_0068, 32'h208, 16'h0707);
        step();
        chk("cm_sticky",  32'(bus.Ctrl_Err), 32'h1);

        // Reset clears sticky flags and the terminal state.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r2_state",   32'(bus.State), 32'h0);
        chk("r2_serr",    32'(bus.Stall_Err), 32'h0);
        chk("r2_cerr",    32'(bus.Ctrl_Err), 32'h0);
        chk("r2_bub",     32'(bus.Bubble_CNT), 32'h0);
        chk("r2_pc",      bus.PC, 32'h0);

        // Long stall: bubble counter and stall run saturate.
        drive(0, 0, 0, 1, 32'h300, 32'h0000_0088, 32'h304, 16'h0808);
        for (int i = 0; i < 65535; i++) step();
        chk("sat_bub_ff", 32'(bus.Bubble_CNT), 32'hFFFF);
        step();
        chk("sat_bub",    32'(bus.Bubble_CNT), 32'hFFFF);
        chk("sat_run",    32'(bus.Stall_Run), 32'hF);
        chk("sat_cerr",   32'(bus.Ctrl_Err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
